// File: rtl/rdft_sliding_bin_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rdft_sliding_bin_if
//  Purpose  : Sample/twiddle stream in, complex bin value and status out, for
//             the sliding-DFT bin stage.
//  Revision : 1.0  initial release
// ============================================================================
interface rdft_sliding_bin_if #(
   parameter int BITS = 16,
   parameter int N    = 8,
   parameter int TW   = 16
);
   localparam int AW = BITS + $clog2(N) + 1;

   logic                   in_valid;
   logic signed [BITS-1:0] in;
   logic signed [BITS-1:0] j_in;
   logic signed [TW-1:0]   tw_re;
   logic signed [TW-1:0]   tw_im;
   logic                   out_valid;
   logic signed [AW-1:0]   out;
   logic signed [AW-1:0]   j_out;
   logic                   primed;
   logic                   ovf;

   // Sample source side
   modport master (
      output in_valid, in, j_in, tw_re, tw_im,
      input  out_valid, out, j_out, primed, ovf
   );

   // DFT stage side
   modport slave (
      input  in_valid, in, j_in, tw_re, tw_im,
      output out_valid, out, j_out, primed, ovf
   );
endinterface
`default_nettype wire

// File: rtl/rdft_sliding_bin.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rdft_sliding_bin
//  Purpose  : Sliding-DFT single-bin stage. Per accepted sample computes
//             S(n) = (S(n-1) + x(n) - x(n-N)) * W with round half-up and
//             saturation; primed/ovf status; synchronous flush.
//  Revision : 1.0  initial release
// ============================================================================
module rdft_sliding_bin #(
   parameter int BITS = 16,
   parameter int N    = 8,
   parameter int TW   = 16
) (
   input logic               clk,
   input logic               rst_n,
   input logic               clear,
   rdft_sliding_bin_if.slave bus
);
   localparam int AW  = BITS + $clog2(N) + 1;
   localparam int PW  = $clog2(N);
   // Product width with headroom: |s| < 2^AW, |tw| <= 2^(TW-1), sum of two products
   localparam int PRW = AW + TW + 2;

   localparam logic [PW:0]            C_FULL = (PW+1)'(N);
   localparam logic signed [PRW-1:0] C_HALF = {{(PRW-TW+2){1'b0}}, 1'b1, {(TW-3){1'b0}}};
   localparam logic signed [PRW-1:0] C_MAX  = {{(PRW-AW+1){1'b0}}, {(AW-1){1'b1}}};
   localparam logic signed [PRW-1:0] C_MIN  = {{(PRW-AW+1){1'b1}}, {(AW-1){1'b0}}};

   // Registered state
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW:0]          fill_q, fill_d;
   logic signed [AW-1:0] acc_re_q, acc_re_d;
   logic signed [AW-1:0] acc_im_q, acc_im_d;
   logic                 out_valid_q, out_valid_d;
   logic                 primed_q, primed_d;
   logic                 ovf_q, ovf_d;

   // Delay line storage (never reset: contents are gated by fill)
   logic signed [BITS-1:0] line_re_q [N];
   logic signed [BITS-1:0] line_im_q [N];

   // Datapath
   logic                   accept;
   logic signed [BITS-1:0] old_re, old_im;
   logic signed [BITS:0]   d_re, d_im;
   logic signed [AW:0]     s_re, s_im;
   logic signed [PRW-1:0]  sx_re, sx_im, twx_re, twx_im;
   logic signed [PRW-1:0]  p_re, p_im;
   logic signed [PRW-1:0]  r_re, r_im;
   logic                   sat_re, sat_im;
   logic signed [AW-1:0]   res_re, res_im;

   // Bin arithmetic for the sample currently presented
   always_comb begin
      accept = bus.in_valid & ~clear;
      old_re = (fill_q == C_FULL) ? line_re_q[wr_ptr_q] : '0;
      old_im = (fill_q == C_FULL) ? line_im_q[wr_ptr_q] : '0;
      d_re   = {bus.in[BITS-1], bus.in}     - {old_re[BITS-1], old_re};
      d_im   = {bus.j_in[BITS-1], bus.j_in} - {old_im[BITS-1], old_im};
      s_re   = {acc_re_q[AW-1], acc_re_q} + {{(AW-BITS){d_re[BITS]}}, d_re};
      s_im   = {acc_im_q[AW-1], acc_im_q} + {{(AW-BITS){d_im[BITS]}}, d_im};
      sx_re  = {{(PRW-AW-1){s_re[AW]}}, s_re};
      sx_im  = {{(PRW-AW-1){s_im[AW]}}, s_im};
      twx_re = {{(PRW-TW){bus.tw_re[TW-1]}}, bus.tw_re};
      twx_im = {{(PRW-TW){bus.tw_im[TW-1]}}, bus.tw_im};
      p_re   = sx_re * twx_re - sx_im * twx_im;
      p_im   = sx_re * twx_im + sx_im * twx_re;
      r_re   = (p_re + C_HALF) >>> (TW-2);
      r_im   = (p_im + C_HALF) >>> (TW-2);
      sat_re = (r_re > C_MAX) || (r_re < C_MIN);
      sat_im = (r_im > C_MAX) || (r_im < C_MIN);
      res_re = (r_re > C_MAX) ? C_MAX[AW-1:0] : (r_re < C_MIN) ? C_MIN[AW-1:0] : r_re[AW-1:0];
      res_im = (r_im > C_MAX) ? C_MAX[AW-1:0] : (r_im < C_MIN) ? C_MIN[AW-1:0] : r_im[AW-1:0];
   end

   // Next-state: flush wins over a coincident sample, idle holds everything
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      primed_d    = primed_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      if (clear) begin
         wr_ptr_d = '0;
         fill_d   = '0;
         acc_re_d = '0;
         acc_im_d = '0;
         primed_d = 1'b0;
         ovf_d    = 1'b0;
      end else if (bus.in_valid) begin
         wr_ptr_d    = wr_ptr_q + 1'b1;
         fill_d      = (fill_q == C_FULL) ? fill_q : fill_q + 1'b1;
         primed_d    = (fill_d == C_FULL);
         acc_re_d    = res_re;
         acc_im_d    = res_im;
         ovf_d       = ovf_q | sat_re | sat_im;
         out_valid_d = 1'b1;
      end
   end

   // State registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         out_valid_q <= 1'b0;
         primed_q    <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         out_valid_q <= out_valid_d;
         primed_q    <= primed_d;
         ovf_q       <= ovf_d;
      end
   end

   // Delay line write: the entry just read as x(n-N) is replaced by x(n)
   always_ff @(posedge clk) begin
      if (accept) begin
         line_re_q[wr_ptr_q] <= bus.in;
         line_im_q[wr_ptr_q] <= bus.j_in;
      end
   end

   // The outputs are the accumulator itself, so they hold between strobes
   assign bus.out       = acc_re_q;
   assign bus.j_out     = acc_im_q;
   assign bus.out_valid = out_valid_q;
   assign bus.primed    = primed_q;
   assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rdft_sliding_bin.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rdft_sliding_bin
//  Purpose  : Directed and randomized checks of rdft_sliding_bin against a
//             sample-history reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rdft_sliding_bin;
   localparam int BITS = 16;
   localparam int N    = 8;
   localparam int TW   = 16;
   localparam int AW   = BITS + $clog2(N) + 1;
   localparam longint MAXV = (longint'(1) <<< (AW-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (AW-1));

   logic clk;
   logic rst_n;
   logic clear;

   rdft_sliding_bin_if #(.BITS(BITS), .N(N), .TW(TW)) bus ();

   rdft_sliding_bin #(.BITS(BITS), .N(N), .TW(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: history of accepted samples since reset/clear
   longint h_re[$];
   longint h_im[$];
   longint m_re, m_im;
   int     m_cnt;
   logic   e_valid, e_primed, e_ovf;

   longint t1_re[12];
   longint t2_re[12];
   longint t2_im[12];

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      h_re.delete();
      h_im.delete();
      m_re  = 0;
      m_im  = 0;
      m_cnt = 0;
      e_ovf = 1'b0;
      e_valid  = 1'b0;
      e_primed = 1'b0;
   endtask

   // Drive one cycle from a falling edge, update model, compare after the rising edge
   task automatic step(input string tag, input logic v, input logic c,
                       input logic signed [BITS-1:0] xr, input logic signed [BITS-1:0] xi,
                       input logic signed [TW-1:0] twr, input logic signed [TW-1:0] twi);
      longint o_r, o_i, s_r, s_i, p_r, p_i, q_r, q_i;
      clear        = c;
      bus.in_valid = v;
      bus.in       = xr;
      bus.j_in     = xi;
      bus.tw_re    = twr;
      bus.tw_im    = twi;
      @(posedge clk);
      #1;
      e_valid = 1'b0;
      if (c) begin
         model_reset();
      end else if (v) begin
         o_r = (h_re.size() == N) ? h_re[0] : 0;
         o_i = (h_im.size() == N) ? h_im[0] : 0;
         if (h_re.size() == N) begin
            void'(h_re.pop_front());
            void'(h_im.pop_front());
         end
         h_re.push_back(longint'(xr));
         h_im.push_back(longint'(xi));
         s_r = m_re + longint'(xr) - o_r;
         s_i = m_im + longint'(xi) - o_i;
         p_r = s_r * longint'(twr) - s_i * longint'(twi);
         p_i = s_r * longint'(twi) + s_i * longint'(twr);
         q_r = (p_r + (longint'(1) <<< (TW-3))) >>> (TW-2);
         q_i = (p_i + (longint'(1) <<< (TW-3))) >>> (TW-2);
         if (q_r > MAXV) begin q_r = MAXV; e_ovf = 1'b1; end
         if (q_r < MINV) begin q_r = MINV; e_ovf = 1'b1; end
         if (q_i > MAXV) begin q_i = MAXV; e_ovf = 1'b1; end
         if (q_i < MINV) begin q_i = MINV; e_ovf = 1'b1; end
         m_re = q_r;
         m_im = q_i;
         m_cnt++;
         e_valid = 1'b1;
      end
      e_primed = (m_cnt >= N);
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(e_valid));
      chk({tag, ".out"},       64'(bus.out),       m_re);
      chk({tag, ".j_out"},     64'(bus.j_out),     m_im);
      chk({tag, ".primed"},    64'(bus.primed),    64'(e_primed));
      chk({tag, ".ovf"},       64'(bus.ovf),       64'(e_ovf));
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, observed=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int k;
      int idx;
      logic v;
      logic signed [BITS-1:0] ri, rj;
      logic signed [TW-1:0]   rtr, rti;

      // Reset state
      rst_n        = 1'b0;
      clear        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in       = '0;
      bus.j_in     = '0;
      bus.tw_re    = '0;
      bus.tw_im    = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset.out",       64'(bus.out),       0);
      chk("reset.j_out",     64'(bus.j_out),     0);
      chk("reset.out_valid", 64'(bus.out_valid), 0);
      chk("reset.primed",    64'(bus.primed),    0);
      chk("reset.ovf",       64'(bus.ovf),       0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: DC input on bin 0
      for (int n = 0; n < 12; n++) begin
         step("t1", 1'b1, 1'b0, 16'sd100, 16'sd0, 16'sh4000, 16'sd0);
         t1_re[n] = 100 * ((n < 8) ? (n + 1) : 8);
         chk("t1.dc_const", 64'(bus.out), t1_re[n]);
         chk("t1.primed_const", 64'(bus.primed), (n >= 7) ? 64'd1 : 64'd0);
      end
      step("t1_idle", 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sh4000, 16'sd0);
      chk("t1.hold", 64'(bus.out), 800);

      // T5: flush collides with a sample
      step("t5_clr", 1'b1, 1'b1, 16'sd555, 16'sd0, 16'sh4000, 16'sd0);
      chk("t5.out_zero", 64'(bus.out), 0);
      chk("t5.no_valid", 64'(bus.out_valid), 0);
      step("t5_next", 1'b1, 1'b0, 16'sd100, 16'sd0, 16'sh4000, 16'sd0);
      chk("t5.out_100", 64'(bus.out), 100);

      // T3: T1 stimulus with random gaps; strobed outputs follow the T1 sequence
      step("t3_clr", 1'b0, 1'b1, 16'sd0, 16'sd0, 16'sh4000, 16'sd0);
      idx = 0;
      k   = 0;
      while (idx < 12 && k < 200) begin
         v = ($urandom_range(0, 1) == 1);
         step("t3", v, 1'b0, 16'sd100, 16'sd0, 16'sh4000, 16'sd0);
         if (bus.out_valid) begin
            chk("t3.seq", 64'(bus.out), t1_re[idx]);
            idx++;
         end
         k++;
      end
      chk("t3.all_strobes", 64'(idx), 12);

      // T4: saturation with twiddle near 2.0
      step("t4_clr", 1'b0, 1'b1, 16'sd0, 16'sd0, 16'sh7FFF, 16'sd0);
      for (int n = 0; n < 20; n++)
         step("t4", 1'b1, 1'b0, 16'sd32767, 16'sd0, 16'sh7FFF, 16'sd0);
      chk("t4.clamp", 64'(bus.out), 524287);
      chk("t4.ovf", 64'(bus.ovf), 1);
      repeat (3) step("t4_idle", 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sh7FFF, 16'sd0);
      chk("t4.ovf_sticky", 64'(bus.ovf), 1);
      step("t4_flush", 1'b0, 1'b1, 16'sd0, 16'sd0, 16'sh7FFF, 16'sd0);
      chk("t4.ovf_cleared", 64'(bus.ovf), 0);

      // T2: impulse on bin 2
      for (int n = 0; n < 12; n++) begin
         step("t2", 1'b1, 1'b0, (n == 0) ? 16'sd1000 : 16'sd0, 16'sd0, 16'sd0, 16'sh4000);
         t2_re[n] = m_re;
         t2_im[n] = m_im;
         if (n < 8) begin
            case (n % 4)
               0: begin chk("t2.re", 64'(bus.out), 0);     chk("t2.im", 64'(bus.j_out), 1000);  end
               1: begin chk("t2.re", 64'(bus.out), -1000); chk("t2.im", 64'(bus.j_out), 0);     end
               2: begin chk("t2.re", 64'(bus.out), 0);     chk("t2.im", 64'(bus.j_out), -1000); end
               default: begin chk("t2.re", 64'(bus.out), 1000); chk("t2.im", 64'(bus.j_out), 0); end
            endcase
         end else begin
            chk("t2.re_zero", 64'(bus.out), 0);
            chk("t2.im_zero", 64'(bus.j_out), 0);
         end
      end

      // T6: async reset in the middle of a T2 replay
      step("t6_clr", 1'b0, 1'b1, 16'sd0, 16'sd0, 16'sd0, 16'sh4000);
      for (int n = 0; n < 5; n++)
         step("t6_pre", 1'b1, 1'b0, (n == 0) ? 16'sd1000 : 16'sd0, 16'sd0, 16'sd0, 16'sh4000);
      bus.in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("t6.async_out",    64'(bus.out),       0);
      chk("t6.async_j_out",  64'(bus.j_out),     0);
      chk("t6.async_valid",  64'(bus.out_valid), 0);
      chk("t6.async_primed", 64'(bus.primed),    0);
      model_reset();
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 12; n++) begin
         step("t6", 1'b1, 1'b0, (n == 0) ? 16'sd1000 : 16'sd0, 16'sd0, 16'sd0, 16'sh4000);
         chk("t6.replay_re", 64'(bus.out),   t2_re[n]);
         chk("t6.replay_im", 64'(bus.j_out), t2_im[n]);
      end

      // Randomized traffic: random samples, twiddles, gaps and occasional flushes
      for (int n = 0; n < 120; n++) begin
         ri  = BITS'($urandom);
         rj  = BITS'($urandom);
         rtr = TW'($urandom);
         rti = TW'($urandom);
         if (n % 40 < 20) begin
            rtr = rtr >>> 2;
            rti = rti >>> 2;
         end
         step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), ri, rj, rtr, rti);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
